// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sequencing one shared 32-bit ALU
//
// alu_arbiter_alu: combinational 32-bit ALU.
//   alu_op [4] in, op1/op2 [32] in, result [32] out, zero out (result == 0).
//
// alu_arbiter: grants one requester at a time, registers its operands into the
// ALU, and returns the registered result to that requester until it accepts it.
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/reqN_ready          request handshake, N = 0/1
//   reqN_op1/reqN_op2/reqN_alu_op  request payload
//   rspN_valid/rspN_ready          response handshake
//   rspN_result/rspN_zero          response payload
//   busy                           an operation is executing or awaiting response

module alu_arbiter_alu #(
  parameter logic [3:0] ALU_OP_AND = 4'b0000,
  parameter logic [3:0] ALU_OP_OR  = 4'b0001,
  parameter logic [3:0] ALU_OP_ADD = 4'b0010,
  parameter logic [3:0] ALU_OP_SUB = 4'b0110,
  parameter logic [3:0] ALU_OP_LT  = 4'b0111,
  parameter logic [3:0] ALU_OP_SRL = 4'b1000,
  parameter logic [3:0] ALU_OP_SLL = 4'b1001,
  parameter logic [3:0] ALU_OP_SRA = 4'b1010,
  parameter logic [3:0] ALU_OP_XOR = 4'b1101
) (
  input  logic [3:0]  alu_op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] result,
  output logic        zero
);

  logic [4:0] shamt;

  assign shamt = op2[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_OP_AND: result = op1 & op2;
      ALU_OP_OR:  result = op1 | op2;
      ALU_OP_ADD: result = op1 + op2;
      ALU_OP_SUB: result = op1 - op2;
      ALU_OP_LT:  result = {31'd0, ($signed(op1) < $signed(op2))};
      ALU_OP_SRL: result = op1 >> shamt;
      ALU_OP_SLL: result = op1 << shamt;
      ALU_OP_SRA: result = $unsigned($signed(op1) >>> shamt);
      ALU_OP_XOR: result = op1 ^ op2;
      // Undefined codes fall through to 0, which also raises zero.
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

module alu_arbiter #(
  parameter logic [3:0] ALU_OP_AND = 4'b0000,
  parameter logic [3:0] ALU_OP_OR  = 4'b0001,
  parameter logic [3:0] ALU_OP_ADD = 4'b0010,
  parameter logic [3:0] ALU_OP_SUB = 4'b0110,
  parameter logic [3:0] ALU_OP_LT  = 4'b0111,
  parameter logic [3:0] ALU_OP_SRL = 4'b1000,
  parameter logic [3:0] ALU_OP_SLL = 4'b1001,
  parameter logic [3:0] ALU_OP_SRA = 4'b1010,
  parameter logic [3:0] ALU_OP_XOR = 4'b1101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [3:0]  req0_alu_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [3:0]  req1_alu_op,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;

  logic        grant;
  logic        owner_rsp_ready;
  logic [31:0] alu_result;
  logic        alu_zero;

  alu_arbiter_alu #(
    .ALU_OP_AND (ALU_OP_AND),
    .ALU_OP_OR  (ALU_OP_OR),
    .ALU_OP_ADD (ALU_OP_ADD),
    .ALU_OP_SUB (ALU_OP_SUB),
    .ALU_OP_LT  (ALU_OP_LT),
    .ALU_OP_SRL (ALU_OP_SRL),
    .ALU_OP_SLL (ALU_OP_SLL),
    .ALU_OP_SRA (ALU_OP_SRA),
    .ALU_OP_XOR (ALU_OP_XOR)
  ) u_alu (
    .alu_op (alu_op_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // On a tie the requester not served last wins; otherwise the lone valid one.
  assign grant = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !grant && !rst;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid &&  grant && !rst;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          owner_d  = grant;
          last_d   = grant;
          op1_d    = grant ? req1_op1    : req0_op1;
          op2_d    = grant ? req1_op2    : req0_op2;
          alu_op_d = grant ? req1_alu_op : req0_alu_op;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d     = alu_result;
        zero_d       = alu_zero;
        rsp0_valid_d = !owner_q;
        rsp1_valid_d =  owner_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's valid is high here, so its ready alone completes.
        if (owner_rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      alu_op_q     <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // The result register is shared; only the owner sees it on its response port.
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = owner_q ? '0 : result_q;
  assign rsp1_result = owner_q ? result_q : '0;
  assign rsp0_zero   = owner_q ? 1'b0 : zero_q;
  assign rsp1_zero   = owner_q ? zero_q : 1'b0;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a transaction model
module tb_alu_arbiter;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic        busy;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_alu_op(req0_alu_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_alu_op(req1_alu_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference ALU from the operation definitions: returns {zero, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned s;
    s = b % 32;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b1000: r = a >> s;
      4'b1001: r = a << s;
      4'b1010: begin
        r = a >> s;
        if (a[31] && s != 0) r = r | ~(32'hFFFF_FFFF >> s);
      end
      4'b1101: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Stimulus controls written by the main sequence.
  req_t q0[$];
  req_t q1[$];
  logic rdy_set0 = 1'b1, rdy_set1 = 1'b1;
  logic rand_gap = 1'b0, rand_rdy = 1'b0;

  // Handshakes seen by the monitor in the cycle just ended.
  logic acc0 = 1'b0, acc1 = 1'b0;

  // Transaction model: phase 0 idle, 1 executing, 2 awaiting response acceptance.
  int          m_phase = 0;
  logic        m_last = 1'b1;
  logic        m_owner = 1'b0;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic        m_just_reset = 1'b0;
  int          done_port[$];
  logic [31:0] done_res[$];
  logic        done_zero[$];
  int          grant_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (!req0_valid || acc0) req0_valid = (q0.size() > 0) && (!rand_gap || $urandom_range(0, 2) != 0);
    if (!req1_valid || acc1) req1_valid = (q1.size() > 0) && (!rand_gap || $urandom_range(0, 2) != 0);
    if (req0_valid) begin
      req0_alu_op = q0[0].op; req0_op1 = q0[0].a; req0_op2 = q0[0].b;
    end
    if (req1_valid) begin
      req1_alu_op = q1[0].op; req1_op1 = q1[0].a; req1_op2 = q1[0].b;
    end
    rsp0_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set0;
    rsp1_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set1;
  end

  always @(negedge clk) begin
    logic        exp_g;
    logic [32:0] exp;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (rst) begin
      check("ready0_in_rst", req0_ready, 0);
      check("ready1_in_rst", req1_ready, 0);
      m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_just_reset = 1'b1;
    end else begin
      if (m_just_reset) begin
        check("rst_rsp0_result", rsp0_result, 0);
        check("rst_rsp1_result", rsp1_result, 0);
        check("rst_rsp0_zero", rsp0_zero, 0);
        check("rst_rsp1_zero", rsp1_zero, 0);
        m_just_reset = 1'b0;
      end
      exp_g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      check("ready0", req0_ready, (m_phase == 0) && req0_valid && !exp_g);
      check("ready1", req1_ready, (m_phase == 0) && req1_valid && exp_g);
      check("busy", busy, m_phase != 0);
      check("rsp0_valid", rsp0_valid, (m_phase == 2) && !m_owner);
      check("rsp1_valid", rsp1_valid, (m_phase == 2) && m_owner);
      if (m_phase == 2) begin
        exp = ref_alu(m_op, m_a, m_b);
        check("rsp_result", m_owner ? rsp1_result : rsp0_result, exp[31:0]);
        check("rsp_zero", m_owner ? rsp1_zero : rsp0_zero, exp[32]);
      end
      if (m_phase == 0) begin
        if (acc0 || acc1) begin
          m_owner = acc1; m_last = acc1;
          m_op = acc1 ? req1_alu_op : req0_alu_op;
          m_a  = acc1 ? req1_op1 : req0_op1;
          m_b  = acc1 ? req1_op2 : req0_op2;
          m_phase = 1;
          grant_cnt++;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_owner ? rsp1_ready : rsp0_ready) begin
        exp = ref_alu(m_op, m_a, m_b);
        done_port.push_back(int'(m_owner));
        done_res.push_back(exp[31:0]);
        done_zero.push_back(exp[32]);
        m_phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_port.size() < n; i++) tick();
    if (done_port.size() < n) check("done_timeout", done_port.size(), n);
  endtask

  task automatic expect_done(input string tag, input int idx, input int port,
                             input logic [31:0] res, input logic zero);
    if (done_port.size() > idx) begin
      check({tag, "_port"}, done_port[idx], port);
      check({tag, "_result"}, done_res[idx], res);
      check({tag, "_zero"}, done_zero[idx], zero);
    end else begin
      check({tag, "_missing"}, done_port.size(), idx + 1);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic req_t rnd_req();
    logic [3:0] codes [11];
    req_t r;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
              4'b1001, 4'b1010, 4'b1101, 4'b1111, 4'b0011};
    r.op = codes[$urandom_range(0, 10)];
    r.a  = $urandom;
    r.b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    return r;
  endfunction

  initial begin
    int d;
    int g;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int g;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single ADD wrapping to zero from requester 0.
    d = done_port.size();
    q0.push_back('{4'b0010, 32'h0000_0005, 32'hFFFF_FFFB});
    wait_done(d + 1, 50);
    expect_done("t1", d, 0, 32'h0, 1'b1);

    // Tie after reset: requester 0 first.
    reset_pulse();
    d = done_port.size();
    q0.push_back('{4'b0110, 32'd7, 32'd3});
    q1.push_back('{4'b0111, 32'hFFFF_FFFF, 32'd1});
    wait_done(d + 2, 50);
    expect_done("t2a", d, 0, 32'd4, 1'b0);
    expect_done("t2b", d + 1, 1, 32'd1, 1'b0);

    // Both held valid: strict alternation.
    d = done_port.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rnd_req());
      q1.push_back(rnd_req());
    end
    wait_done(d + 6, 100);
    for (int i = 0; i < 6; i++)
      if (done_port.size() > d + i) check("t3_order", done_port[d + i], i % 2);

    // Backpressure on requester 1 with requester 0 waiting.
    d = done_port.size();
    g = grant_cnt;
    rdy_set1 = 1'b0;
    q1.push_back('{4'b1010, 32'h8000_0000, 32'd4});
    for (int i = 0; i < 20 && grant_cnt == g; i++) tick();
    check("t4_granted", grant_cnt, g + 1);
    q0.push_back('{4'b0010, 32'd1, 32'd2});
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_rsp1_valid", rsp1_valid, 1);
      check("t4_rsp1_result", rsp1_result, 32'hF800_0000);
      check("t4_busy", busy, 1);
      check("t4_req0_ready", req0_ready, 0);
      tick();
    end
    check("t4_held", done_port.size(), d);
    rdy_set1 = 1'b1;
    wait_done(d + 2, 50);
    expect_done("t4a", d, 1, 32'hF800_0000, 1'b0);
    expect_done("t4b", d + 1, 0, 32'd3, 1'b0);

    // Reset during EXEC abandons the operation.
    d = done_port.size();
    g = grant_cnt;
    q0.push_back('{4'b0001, 32'h0F, 32'hF0});
    for (int i = 0; i < 20 && grant_cnt == g; i++) tick();
    check("t5_granted", grant_cnt, g + 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t5_busy", busy, 0);
    check("t5_rsp0_valid", rsp0_valid, 0);
    tick();
    check("t5_no_rsp", done_port.size(), d);
    q0.push_back('{4'b1001, 32'd1, 32'd31});
    q1.push_back('{4'b1000, 32'h8000_0000, 32'd31});
    wait_done(d + 2, 50);
    expect_done("t5a", d, 0, 32'h8000_0000, 1'b0);
    expect_done("t5b", d + 1, 1, 32'd1, 1'b0);

    // Undefined opcode.
    d = done_port.size();
    q0.push_back('{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0});
    wait_done(d + 1, 50);
    expect_done("t6", d, 0, 32'h0, 1'b1);

    // Randomized traffic with gaps and random response backpressure.
    d = done_port.size();
    rand_gap = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      q0.push_back(rnd_req());
      q1.push_back(rnd_req());
    end
    wait_done(d + 60, 3000);
    rand_rdy = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 32-bit ALU. Two requesters (e.g. address-generation and execute units) each present an operation over a valid/ready handshake. The block grants one request at a time, registers its operands into the single ALU instance, and returns the registered result and zero flag only to the granted requester, holding the response until that requester accepts it.

## Interface
- ALU_OP_* encodings, default AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, LT=4'b0111, SRL=4'b1000, SLL=4'b1001, SRA=4'b1010, XOR=4'b1101; passed unchanged to the ALU instance.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  arbiter accepts requester 0's operation this cycle.
- req0_op1, req0_op2  in  32  operands; signed for LT/SRA.
- req0_alu_op  in  4  ALU operation code.
- rsp0_valid  out  1  response for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes the response.
- rsp0_result  out  32  ALU result.
- rsp0_zero  out  1  result == 0.
- req1_* and rsp1_*: identical set for requester 1.
- busy  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the valid requester. If both are valid, grant goes to the requester that was not last granted.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N && !rst. This is combinational from valid.
  - On reqN_valid && reqN_ready: latch op1, op2 and alu_op into operand registers; set owner=N and last=N; go to EXEC.
- EXEC (1 cycle):
  - The ALU is driven from the operand registers.
  - At the clock edge, the ALU result and zero flag are captured into the response registers.
  - rspN_valid for the owner is set; go to RESP.
- RESP:
  - rsp<owner>_valid stays high. Result and zero are held stable.
  - On rsp<owner>_valid && rsp<owner>_ready: clear valid and go to IDLE.
  - The non-owner's rsp_valid stays 0.
- No request is accepted outside IDLE. Both req*_ready are 0 in EXEC and RESP.
- Requester rules:
  - Hold reqN_valid and payload stable until the handshake completes.
  - reqN_valid must not depend on reqN_ready.
- ALU behaviour:
  - 32-bit wrap-around arithmetic; no overflow flag.
  - Shifts use op2[4:0].
  - LT is signed, returning 32'd1 or 32'd0.
  - SRA sign-extends.
  - An undefined alu_op yields result 0 and zero=1.
- Pointer `last` resets to 1, so requester 0 wins the first tie.

## Timing
- Reset values: state=IDLE, last=1, owner=0, rsp0_valid=rsp1_valid=0, rsp*_result=0, rsp*_zero=0, busy=0. req*_ready=0 while rst is high.
- Latency: handshake at edge t gives EXEC in cycle t+1 and rsp_valid high in cycle t+2.
- Minimum issue interval: 3 cycles (accept, EXEC, RESP with rsp_ready already high). The next accept can occur in the cycle after the response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely, with outputs stable and no new grants.
- Reset mid-operation (EXEC or RESP): the operation is abandoned, no response is issued, and all reset values apply on the next cycle.
- A request that drops valid before being granted is not executed. Doing so violates the protocol; the arbiter does not check for it.
- rsp_ready asserted while rsp_valid is low is ignored.

## Test plan
- Single op from requester 0: ADD op1=0x00000005, op2=0xFFFFFFFB, rsp0_ready=1. Required: req0_ready at t, rsp0_valid at t+2, rsp0_result=0, rsp0_zero=1, rsp1_valid=0 throughout.
- Tie after reset: both valid at once, req0 = SUB 7-3, req1 = LT -1<1. Required: req0 granted first with result 4, zero=0. Then req1 granted with result 1.
- Round-robin fairness: both requesters held continuously valid for 6 operations. Required: grant order 0,1,0,1,0,1, with no grant in any EXEC or RESP cycle.
- Backpressure: req1 = SRA op1=0x80000000, op2=4, with rsp1_ready low for 5 cycles. Required: rsp1_result=0xF8000000 held stable, busy=1, req0_ready=0 throughout, and completion on the cycle rsp1_ready rises.
- Reset mid-op: assert rst during EXEC. Required: the next cycle shows all outputs at reset values, no rsp_valid pulse, and a tie then grants requester 0.
- Undefined op 4'b1111 from req0. Required: result=0, zero=1.
